// File: rtl/window_compositor.sv
// rtl/window_compositor.sv - N-channel picture-in-picture compositor with double-buffered window positions
// Hit-tests every window per scan pixel, issues local frame-buffer addresses, returns the winning pixel.
module window_compositor #(
  parameter int                     NUM_CH   = 4,
  parameter int                     XW       = 10,
  parameter int                     WIN_W    = 174,
  parameter int                     WIN_H    = 144,
  parameter int                     H_RES    = 640,
  parameter int                     V_RES    = 480,
  parameter int                     RD_LAT   = 1,
  parameter int                     STEP     = 1,
  parameter logic [15:0]            BG_COLOR = 16'h0000,
  parameter logic [NUM_CH*2*XW-1:0] INIT_XY  = '0
) (
  input  logic                 rd_clk,
  input  logic                 reset,
  input  logic [XW-1:0]        pix_x,
  input  logic [XW-1:0]        pix_y,
  input  logic                 pix_valid,
  input  logic                 frame_start,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_ch,
  input  logic [XW-1:0]        cfg_x,
  input  logic [XW-1:0]        cfg_y,
  input  logic                 nudge_req,
  input  logic [2:0]           nudge_ch,
  input  logic                 nudge_axis,
  input  logic                 nudge_dir,
  output logic [NUM_CH*XW-1:0] rd_x,
  output logic [NUM_CH*XW-1:0] rd_y,
  input  logic [NUM_CH*16-1:0] rd_data,
  output logic [15:0]          out_pixel,
  output logic                 out_valid,
  output logic [3:0]           out_ch
);
  localparam int             CW    = XW + 1;
  localparam logic [CW-1:0]  X_MAX = CW'(H_RES - WIN_W);
  localparam logic [CW-1:0]  Y_MAX = CW'(V_RES - WIN_H);
  localparam logic [3:0]     NONE  = 4'(NUM_CH);

  logic [XW-1:0] sh_x  [NUM_CH];
  logic [XW-1:0] sh_y  [NUM_CH];
  logic [XW-1:0] act_x [NUM_CH];
  logic [XW-1:0] act_y [NUM_CH];
  logic          nudge_q;
  logic          nudge_rise;

  assign nudge_rise = nudge_req & ~nudge_q;

  // Saturating step at one bit wider than the coordinate, so a decrement at 0 cannot wrap.
  function automatic logic [XW-1:0] nudged(input logic [XW-1:0] cur, input logic dir,
                                           input logic [CW-1:0] lim);
    logic [CW-1:0] v;
    if (dir) v = ({1'b0, cur} < CW'(STEP)) ? '0 : {1'b0, cur} - CW'(STEP);
    else     v = {1'b0, cur} + CW'(STEP);
    if (v > lim) v = lim;
    return v[XW-1:0];
  endfunction

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      nudge_q <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        sh_x[c]  <= INIT_XY[c*2*XW +: XW];
        sh_y[c]  <= INIT_XY[c*2*XW+XW +: XW];
        act_x[c] <= INIT_XY[c*2*XW +: XW];
        act_y[c] <= INIT_XY[c*2*XW+XW +: XW];
      end
    end else begin
      nudge_q <= nudge_req;
      for (int c = 0; c < NUM_CH; c++) begin
        if (frame_start) begin
          act_x[c] <= sh_x[c];
          act_y[c] <= sh_y[c];
        end
        if (cfg_we && cfg_ch == 3'(c)) begin
          sh_x[c] <= cfg_x;
          sh_y[c] <= cfg_y;
        end else if (nudge_rise && nudge_ch == 3'(c)) begin
          if (nudge_axis) sh_y[c] <= nudged(sh_y[c], nudge_dir, Y_MAX);
          else            sh_x[c] <= nudged(sh_x[c], nudge_dir, X_MAX);
        end
      end
    end
  end

  logic [NUM_CH-1:0] hit;
  logic [3:0]        win_ch;

  always_comb begin
    hit    = '0;
    win_ch = NONE;
    for (int c = 0; c < NUM_CH; c++) begin
      hit[c] = ({1'b0, pix_x} >= {1'b0, act_x[c]}) &&
               ({1'b0, pix_x} <  {1'b0, act_x[c]} + CW'(WIN_W)) &&
               ({1'b0, pix_y} >= {1'b0, act_y[c]}) &&
               ({1'b0, pix_y} <  {1'b0, act_y[c]} + CW'(WIN_H));
    end
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (hit[c]) win_ch = 4'(c);
    end
    if (!pix_valid) win_ch = NONE;
  end

  // Index 0 is the stage-1 register; index RD_LAT lines up with rd_data.
  logic [3:0]    ch_pipe [RD_LAT+1];
  logic [RD_LAT:0] val_pipe;

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      rd_x     <= '0;
      rd_y     <= '0;
      val_pipe <= '0;
      for (int i = 0; i <= RD_LAT; i++) ch_pipe[i] <= NONE;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        rd_x[c*XW +: XW] <= pix_x - act_x[c];
        rd_y[c*XW +: XW] <= pix_y - act_y[c];
      end
      ch_pipe[0]  <= win_ch;
      val_pipe[0] <= pix_valid;
      for (int i = 1; i <= RD_LAT; i++) begin
        ch_pipe[i]  <= ch_pipe[i-1];
        val_pipe[i] <= val_pipe[i-1];
      end
    end
  end

  logic [3:0]  ch_d;
  logic [15:0] sel_pix;

  assign ch_d = ch_pipe[RD_LAT];

  always_comb begin
    sel_pix = BG_COLOR;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_d == 4'(c)) sel_pix = rd_data[c*16 +: 16];
    end
  end

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      out_pixel <= BG_COLOR;
      out_valid <= 1'b0;
      out_ch    <= NONE;
    end else begin
      out_pixel <= sel_pix;
      out_valid <= val_pipe[RD_LAT];
      out_ch    <= ch_d;
    end
  end
endmodule
